// File: rtl/fetch_queue.sv
// Instruction-fetch stage: registers the PC alongside the synchronous imem read and buffers
// (pc, instr) pairs in a fall-through FIFO; a full FIFO drops the fetch and requests a replay.
module fetch_queue #(
    parameter int INSTR_MEM_WIDTH = 32,
    parameter int ADDR_W          = INSTR_MEM_WIDTH,
    parameter int DEPTH           = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    output logic              replay,
    output logic [ADDR_W-1:0] replay_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_pc_q, s1_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];

    logic full, deq, enq;

    assign imem_addr = pc_in;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_instr = instr_mem[rd_ptr_q];
    assign replay_pc = s1_pc_q;

    always_comb begin
        full   = (count_q == CNT_W'(DEPTH));
        deq    = out_valid & out_ready;
        enq    = s1_valid_q & ~flush & (~full | deq);
        // Replay squashes the fetch now in S0 so the PC can re-present s1_pc next cycle.
        replay = s1_valid_q & full & ~deq & ~flush;

        s1_valid_d = ~flush & ~replay;
        s1_pc_d    = pc_in;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (enq && !deq)      count_d = count_q + CNT_W'(1);
            else if (deq && !enq) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pc_q    <= s1_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]    <= s1_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
